// File: rtl/circuit6_hlsm.sv
// circuit6 datapath, z = ((a % c) == zero) ? a - 1 : c + 1, using an iterative restoring modulo.
// Optional macro CIRCUIT6_HLSM_ZDIV_FAST_EN: when c=0, skip the divide loop (g = a either way).
module circuit6_hlsm #(
    parameter int DATAWIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] c,
    input  logic [DATAWIDTH-1:0] zero,
    output logic [DATAWIDTH-1:0] z,
    output logic                 done,
    output logic                 busy
);
    localparam int W     = DATAWIDTH;
    localparam int CNT_W = (W > 2) ? $clog2(W) : 1;
    localparam logic [W-1:0] ONE = W'(1);

    typedef enum logic [1:0] {IDLE, DIV, SEL, DONE} state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     c_q, c_d;
    logic [W-1:0]     zero_q, zero_d;
    logic [W-1:0]     q_q, q_d;
    logic [W:0]       r_q, r_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     z_q, z_d;
    logic [W:0]       rs;
    logic [W-1:0]     g;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        c_d     = c_q;
        zero_d  = zero_q;
        q_d     = q_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        z_d     = z_q;
        rs      = {r_q[W-1:0], q_q[W-1]};
        g       = r_q[W-1:0];
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    c_d     = c;
                    zero_d  = zero;
                    q_d     = a;
                    r_d     = '0;
                    cnt_d   = CNT_W'(W - 1);
                    state_d = DIV;
`ifdef CIRCUIT6_HLSM_ZDIV_FAST_EN
                    // Divisor zero leaves the remainder equal to a, so load it directly.
                    if (c == '0) begin
                        r_d     = {1'b0, a};
                        state_d = SEL;
                    end
`endif
                end
            end
            DIV: begin
                q_d = q_q << 1;
                // With c=0 every compare passes, so r simply accumulates a.
                if (rs >= {1'b0, c_q}) begin
                    r_d = rs - {1'b0, c_q};
                end else begin
                    r_d = rs;
                end
                if (cnt_q == '0) begin
                    state_d = SEL;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            SEL: begin
                z_d     = (g == zero_q) ? (a_q - ONE) : (c_q + ONE);
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            c_q     <= '0;
            zero_q  <= '0;
            q_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            z_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            c_q     <= c_d;
            zero_q  <= zero_d;
            q_q     <= q_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            z_q     <= z_d;
        end
    end

    assign z    = z_q;
    assign done = (state_q == DONE);
    assign busy = (state_q != IDLE);
endmodule

// File: tb/tb_circuit6_hlsm.sv
// Self-checking bench for circuit6_hlsm: cycle-count reference model plus directed literal cases.
// Honours CIRCUIT6_HLSM_ZDIV_FAST_EN for the expected c=0 latency.
module tb_circuit6_hlsm;
    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a_in, c_in, zero_in;
    logic [W-1:0] z;
    logic         done, busy;

    int checks   = 0;
    int failures = 0;

    circuit6_hlsm #(.DATAWIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a_in), .c(c_in), .zero(zero_in),
        .z(z), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_z(input logic [W-1:0] a, input logic [W-1:0] c,
                                           input logic [W-1:0] zr);
        logic [W-1:0] g;
        g = (c == 0) ? a : (a % c);
        return (g == zr) ? a - 64'd1 : c + 64'd1;
    endfunction

    function automatic int ref_len(input logic [W-1:0] c);
`ifdef CIRCUIT6_HLSM_ZDIV_FAST_EN
        if (c == 0) return 2;
`endif
        return W + 2;
    endfunction

    // Model: m_n counts busy cycles since the accepting edge; done lands on cycle m_len.
    int           m_n    = 0;
    int           m_len  = 0;
    bit           m_live = 0;
    logic [W-1:0] m_z    = '0;
    logic [W-1:0] m_pend = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_n    = 0;
            m_z    = '0;
            m_live = 1;
        end else if (m_live) begin
            if (m_n == 0) begin
                if (start) begin
                    m_pend = ref_z(a_in, c_in, zero_in);
                    m_len  = ref_len(c_in);
                    m_n    = 1;
                end
            end else if (m_n == m_len) begin
                m_n = 0;
            end else begin
                m_n++;
                if (m_n == m_len) m_z = m_pend;
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("busy", {63'd0, busy}, {63'd0, (m_n != 0)});
            chk("done", {63'd0, done}, {63'd0, (m_n != 0 && m_n == m_len)});
            chk("z", z, m_z);
        end
    end

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] c, input logic [W-1:0] zr,
                          input int pulse_at, input bit pulse_done, input int rst_at,
                          output logic [W-1:0] z_got, output int lat);
        @(negedge clk);
        start = 1'b1; a_in = a; c_in = c; zero_in = zr;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 200) begin
            if (lat == pulse_at) begin
                start = 1'b1; a_in = 64'd123; c_in = 64'd7; zero_in = 64'd0;
            end
            if (lat == rst_at) rst = 1'b1;
            @(negedge clk);
            start = 1'b0;
            rst   = 1'b0;
            lat++;
            if (rst_at >= 0 && lat == rst_at + 1) break;
        end
        z_got = z;
        if (rst_at < 0) begin
            if (pulse_done) begin
                start = 1'b1; a_in = 64'd55; c_in = 64'd2; zero_in = 64'd1;
            end
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    initial begin
        logic [W-1:0] zg, ra, rc, rz;
        int           lat;
        rst = 1'b1; start = 1'b0; a_in = '0; c_in = '0; zero_in = '0;
        repeat (3) @(negedge clk);
        chk("reset_z", z, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        rst = 1'b0;

        run_op(64'd10, 64'd3, 64'd1, -1, 0, -1, zg, lat);
        chk("a10c3_z", zg, 64'd9);
        chk("a10c3_lat", 64'(lat), 64'd66);
        run_op(64'd10, 64'd5, 64'd1, -1, 0, -1, zg, lat);
        chk("a10c5_z", zg, 64'd6);
        run_op(64'd0, 64'd1, 64'd0, -1, 0, -1, zg, lat);
        chk("dec_wrap_z", zg, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op(64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, -1, 0, -1, zg, lat);
        chk("inc_wrap_z", zg, 64'd0);
        run_op(64'd7, 64'd0, 64'd7, -1, 0, -1, zg, lat);
        chk("div0_z", zg, 64'd6);
`ifdef CIRCUIT6_HLSM_ZDIV_FAST_EN
        chk("div0_lat", 64'(lat), 64'd2);
`else
        chk("div0_lat", 64'(lat), 64'd66);
`endif
        run_op(64'd10, 64'd3, 64'd1, 10, 1, -1, zg, lat);
        chk("ignore_start_z", zg, 64'd9);
        chk("ignore_start_lat", 64'(lat), 64'd66);
        chk("ignore_start_idle", {63'd0, busy}, 64'd0);

        run_op(64'd10, 64'd3, 64'd1, -1, 0, 20, zg, lat);
        chk("midrst_z", z, 64'd0);
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_done", {63'd0, done}, 64'd0);
        run_op(64'd9, 64'd4, 64'd1, -1, 0, -1, zg, lat);
        chk("after_rst_z", zg, 64'd8);
        chk("after_rst_lat", 64'(lat), 64'd66);

        for (int i = 0; i < 32; i++) begin
            ra = {$urandom, $urandom};
            case (i % 4)
                0: rc = 64'd0;
                1: rc = 64'($urandom_range(1, 20));
                2: rc = {$urandom, $urandom};
                default: rc = 64'($urandom);
            endcase
            if (i % 2 == 0) rz = (rc == 0) ? ra : ra % rc;
            else rz = 64'($urandom_range(0, 3));
            run_op(ra, rc, rz, -1, 0, -1, zg, lat);
            chk("rand_z", zg, ref_z(ra, rc, rz));
            chk("rand_lat", 64'(lat), 64'(ref_len(rc)));
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
